// File: rtl/gpio_lite_arbiter19_pkg.sv
// gpio_lite_arbiter19_pkg: shared types and constants for the GPIO lite register-port arbiter.
// Contents: FSM state type, default address/data widths, subunit register map used by benches.
// Optional feature macro used by the arbiter: GPIO_ARB_LOCK_EN.
package gpio_arb_pkg19;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    localparam logic [5:0] REG_DIR      = 6'h04;
    localparam logic [5:0] REG_OUT_EN   = 6'h08;
    localparam logic [5:0] REG_OUT_VAL  = 6'h0C;
    localparam logic [5:0] REG_IN_VAL   = 6'h10;
    localparam logic [5:0] REG_INT_STAT = 6'h20;
endpackage

// File: rtl/gpio_lite_arbiter19_if.sv
// gpio_lite_arbiter19_if: requester-side and subunit-side bus of the GPIO lite arbiter.
// Requester side: req, req_write, req_addr, req_wdata in; gnt, done, rsp_rdata, busy out.
// Subunit side: gpio_read, gpio_write, gpio_addr, gpio_wdata out; gpio_rdata in.
// Modport slave is the arbiter view, master is the environment (requesters + subunit) view.
interface gpio_lite_arbiter19_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    logic                      gpio_read;
    logic                      gpio_write;
    logic [ADDR_W-1:0]         gpio_addr;
    logic [DATA_W-1:0]         gpio_wdata;
    logic [DATA_W-1:0]         gpio_rdata;

    modport slave (
        input  req, req_write, req_addr, req_wdata, gpio_rdata,
        output gnt, done, rsp_rdata, busy, gpio_read, gpio_write, gpio_addr, gpio_wdata
    );
    modport master (
        output req, req_write, req_addr, req_wdata, gpio_rdata,
        input  gnt, done, rsp_rdata, busy, gpio_read, gpio_write, gpio_addr, gpio_wdata
    );
endinterface

// File: rtl/gpio_lite_arbiter19_rr_pick.sv
// gpio_rr_pick19: combinational round-robin picker, reusable by other lite peripherals.
// Ports: req_i request vector, last_i index of the previous winner;
//        onehot_o one-hot winner (0 when no request), idx_o winner index.
// Search starts at last_i+1 and wraps from N-1 to 0.
module gpio_rr_pick19 #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o
);
    // Walk from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        idx_o = '0;
        for (int k = N; k >= 1; k--)
            if (req_i[IW'((int'(last_i) + k) % N)]) idx_o = IW'((int'(last_i) + k) % N);
        onehot_o = (|req_i) ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/gpio_lite_arbiter19.sv
// gpio_lite_arbiter19: round-robin arbiter sharing one GPIO lite register port, one strobe per access.
// Ports: pclk19 clock, n_reset19 async active-low reset, bus (slave modport of gpio_lite_arbiter19_if),
//        req_lock_i per-requester lock request (only when GPIO_ARB_LOCK_EN is defined).
// Flow: IDLE (arbitrate, latch command) -> ISSUE (gnt + strobe) -> CAPTURE (latch read data) -> IDLE (done).
module gpio_lite_arbiter19
    import gpio_arb_pkg19::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input logic pclk19,
    input logic n_reset19,
`ifdef GPIO_ARB_LOCK_EN
    input logic [NUM_REQ-1:0] req_lock_i,
`endif
    gpio_lite_arbiter19_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       last_q, last_d, sel_idx, pick_idx;
    logic [NUM_REQ-1:0]  win_oh_q, win_oh_d, done_q, done_d, sel_oh, pick_oh;
    logic                write_q, write_d, busy_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;

    gpio_rr_pick19 #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i    (bus.req),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

`ifdef GPIO_ARB_LOCK_EN
    logic lock_q, lock_d;
    // A locked requester keeps the port for as long as it keeps requesting.
    assign sel_idx = (lock_q && bus.req[last_q]) ? last_q : pick_idx;
    assign sel_oh  = (lock_q && bus.req[last_q]) ? (NUM_REQ'(1) << last_q) : pick_oh;
    always_ff @(posedge pclk19 or negedge n_reset19)
        if (!n_reset19) lock_q <= 1'b0;
        else            lock_q <= lock_d;
`else
    assign sel_idx = pick_idx;
    assign sel_oh  = pick_oh;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_oh_d = win_oh_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = '0;
`ifdef GPIO_ARB_LOCK_EN
        lock_d   = (state_q == IDLE && !bus.req[last_q]) ? 1'b0 : lock_q;
`endif
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d  = ISSUE;
                last_d   = sel_idx;
                win_oh_d = sel_oh;
                write_d  = bus.req_write[sel_idx];
                addr_d   = bus.req_addr[sel_idx*ADDR_W +: ADDR_W];
                wdata_d  = bus.req_wdata[sel_idx*DATA_W +: DATA_W];
`ifdef GPIO_ARB_LOCK_EN
                lock_d   = req_lock_i[sel_idx];
`endif
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                rdata_d = write_q ? '0 : bus.gpio_rdata;
                done_d  = win_oh_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk19 or negedge n_reset19)
        if (!n_reset19) begin
            state_q  <= IDLE;
            last_q   <= IW'(NUM_REQ - 1);
            win_oh_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_oh_q <= win_oh_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= state_d != IDLE;
        end

    // gnt and strobes decode only registered state, never req.
    assign bus.gnt        = (state_q == ISSUE) ? win_oh_q : '0;
    assign bus.gpio_read  = (state_q == ISSUE) && !write_q;
    assign bus.gpio_write = (state_q == ISSUE) && write_q;
    assign bus.gpio_addr  = addr_q;
    assign bus.gpio_wdata = wdata_q;
    assign bus.done       = done_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_gpio_lite_arbiter19.sv
// tb_gpio_lite_arbiter19: self-checking bench for gpio_lite_arbiter19 with a behavioural GPIO subunit.
module tb_gpio_lite_arbiter19;
    import gpio_arb_pkg19::*;
    localparam int N = 3, AW = 6, DW = 16;

    logic pclk19 = 1'b0;
    logic n_reset19 = 1'b0;
    always #5 pclk19 = ~pclk19;

    gpio_lite_arbiter19_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef GPIO_ARB_LOCK_EN
    logic [N-1:0] req_lock = '0;
`endif

    gpio_lite_arbiter19 #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk19    (pclk19),
        .n_reset19 (n_reset19),
`ifdef GPIO_ARB_LOCK_EN
        .req_lock_i(req_lock),
`endif
        .bus       (bus.slave)
    );

    // Subunit: registered read data one cycle after gpio_read, interrupt status clears on read.
    logic [DW-1:0] sub_mem [64];
    logic sub_clr = 1'b1, irq_set = 1'b0;
    int rd_cnt = 0;
    always @(posedge pclk19) begin
        if (sub_clr) begin
            for (int i = 0; i < 64; i++) sub_mem[i] <= '0;
        end else begin
            if (bus.gpio_write) sub_mem[bus.gpio_addr] <= bus.gpio_wdata;
            if (bus.gpio_read && bus.gpio_addr == REG_INT_STAT) sub_mem[REG_INT_STAT] <= '0;
            if (irq_set) sub_mem[REG_INT_STAT] <= sub_mem[REG_INT_STAT] | 16'h0004;
        end
        bus.gpio_rdata <= bus.gpio_read ? sub_mem[bus.gpio_addr] : '0;
        rd_cnt <= rd_cnt + (bus.gpio_read ? 1 : 0);
    end

    // Reference model: register contents, last winner, and each requester's held command.
    logic [DW-1:0] ref_mem [64];
    int            last_m;
    logic          m_wr   [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_wd   [N];
    int checks = 0, errors = 0;

    task automatic step();
        @(posedge pclk19);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int last, input logic [N-1:0] p);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic set_cmd(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr[r] = wr;
        m_addr[r] = a;
        m_wd[r] = d;
        bus.req_write[r] = wr;
        bus.req_addr[r*AW +: AW] = a;
        bus.req_wdata[r*DW +: DW] = d;
    endtask

    // Raise requests p, serve n accesses; keep=1 leaves every req high until the last grant.
    task automatic run(input logic [N-1:0] p, input int n, input bit keep);
        logic [N-1:0] pend;
        int w, gap, rc;
        pend = p;
        bus.req = p;
        for (int i = 0; i < n; i++) begin
            w = rr(last_m, pend);
            last_m = w;
            rc = rd_cnt;
            step();
            gap = 1;
            while (bus.gnt === '0 && gap < 3 * N + 3) begin
                step();
                gap++;
            end
            chk("gnt", 32'(bus.gnt), 32'(1 << w));
            chk("gnt_latency", gap, 1);
            chk("busy_issue", 32'(bus.busy), 1);
            chk("gpio_read", 32'(bus.gpio_read), 32'(!m_wr[w]));
            chk("gpio_write", 32'(bus.gpio_write), 32'(m_wr[w]));
            chk("gpio_addr", 32'(bus.gpio_addr), 32'(m_addr[w]));
            if (m_wr[w]) chk("gpio_wdata", 32'(bus.gpio_wdata), 32'(m_wd[w]));
            if (!keep) begin
                pend[w] = 1'b0;
                bus.req[w] = 1'b0;
            end else if (i == n - 1) bus.req = '0;
            step();
            chk("strobe_one_cycle", 32'({bus.gpio_read, bus.gpio_write}), 0);
            chk("done_early", 32'(bus.done), 0);
            step();
            chk("done", 32'(bus.done), 32'(1 << w));
            chk("rsp_rdata", 32'(bus.rsp_rdata), m_wr[w] ? 32'(0) : 32'(ref_mem[m_addr[w]]));
            chk("busy_done", 32'(bus.busy), 0);
            chk("read_pulses", rd_cnt - rc, m_wr[w] ? 0 : 1);
            if (m_wr[w]) ref_mem[m_addr[w]] = m_wd[w];
            else if (m_addr[w] == REG_INT_STAT) ref_mem[REG_INT_STAT] = '0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_rsp"}, 32'(bus.rsp_rdata), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_strobes"}, 32'({bus.gpio_read, bus.gpio_write}), 0);
        chk({tag, "_addr"}, 32'(bus.gpio_addr), 0);
        chk({tag, "_wdata"}, 32'(bus.gpio_wdata), 0);
    endtask

    initial begin
        logic [N-1:0] p;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        bus.req = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        last_m = N - 1;
        step();
        step();
        chk_all_zero("reset");
        sub_clr = 1'b0;
        n_reset19 = 1'b1;

        // Contention from reset: all requesters keep reading, order 0,1,2,0.
        for (int r = 0; r < N; r++) set_cmd(r, 1'b0, REG_IN_VAL, '0);
        run('1, 4, 1'b1);

        // Write output value, then requester 1 reads it back.
        set_cmd(0, 1'b1, REG_OUT_VAL, 16'hA5A5);
        run(3'b001, 1, 1'b0);
        set_cmd(1, 1'b0, REG_OUT_VAL, '0);
        run(3'b010, 1, 1'b0);
        chk("single_read_value", 32'(bus.rsp_rdata), 32'h0000A5A5);

        // Read-to-clear interrupt status.
        irq_set = 1'b1;
        step();
        irq_set = 1'b0;
        ref_mem[REG_INT_STAT] = ref_mem[REG_INT_STAT] | 16'h0004;
        set_cmd(2, 1'b0, REG_INT_STAT, '0);
        run(3'b100, 1, 1'b0);
        chk("irq_first_read", 32'(bus.rsp_rdata), 32'h0004);
        run(3'b100, 1, 1'b0);
        chk("irq_second_read", 32'(bus.rsp_rdata), 32'h0000);

        // Write to direction register.
        set_cmd(0, 1'b1, REG_DIR, 16'h1234);
        run(3'b001, 1, 1'b0);

        // Randomised contention rounds.
        for (int t = 0; t < 12; t++) begin
            p = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++)
                if (p[r]) set_cmd(r, 1'($urandom % 2), AW'($urandom % 64), DW'($urandom));
            run(p, $countones(p), 1'b0);
        end

        // Reset during CAPTURE: outputs clear at once, no done, requester 0 wins afterwards.
        set_cmd(1, 1'b0, REG_OUT_VAL, '0);
        bus.req = 3'b010;
        step();
        bus.req = '0;
        step();
        n_reset19 = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        step();
        chk("mid_reset_no_done", 32'(bus.done), 0);
        n_reset19 = 1'b1;
        last_m = N - 1;
        step();
        chk("post_reset_no_done", 32'(bus.done), 0);
        for (int r = 0; r < N; r++) set_cmd(r, 1'b0, REG_OUT_VAL, '0);
        run('1, N, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
